// File: rtl/mcpu_core_fetch_pkg.sv
// -----------------------------------------------------------------------------
// mcpu_core_fetch_pkg
// Shared definitions for the fetch-side address translation slice: default
// virtual PC / page-offset widths and the translation FSM state encoding.
// -----------------------------------------------------------------------------
package mcpu_core_fetch_pkg;

  localparam int unsigned PC_W_DEF     = 28;  // virtual PC width in instruction words
  localparam int unsigned PG_OFF_W_DEF = 8;   // page-offset bits

  // RUN  : translating from the micro-ITLB (or bypassing with paging off)
  // MISS : waiting on the shared ITLB for the current page
  // FAULT: the current page faulted; hold until redirected
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_MISS  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/mcpu_core_uitlb_cam.sv
// -----------------------------------------------------------------------------
// mcpu_core_uitlb_cam
// Small fully-associative micro-ITLB. Combinational lookup (lowest matching
// index wins), single-entry fill at a round-robin pointer, and bulk
// invalidate that also rewinds the pointer. Invalidate beats a coincident fill.
//
// Ports
//   clk, rst_n      : clock, synchronous active-low reset (valid bits, pointer)
//   lookup_page_i   : page number to look up
//   hit_o           : some valid entry matches lookup_page_i
//   hit_data_o      : physical page of the matching entry (0 when no hit)
//   fill_i          : write {fill_page_i, fill_data_i} at the pointer
//   fill_page_i     : tag to write
//   fill_data_i     : physical page to write
//   inval_i         : clear all valid bits and the pointer
// -----------------------------------------------------------------------------
module mcpu_core_uitlb_cam #(
  parameter int unsigned PN_W        = 20,
  parameter int unsigned NUM_ENTRIES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PN_W-1:0] lookup_page_i,
  output logic            hit_o,
  output logic [PN_W-1:0] hit_data_o,
  input  logic            fill_i,
  input  logic [PN_W-1:0] fill_page_i,
  input  logic [PN_W-1:0] fill_data_i,
  input  logic            inval_i
);

  localparam int unsigned PTR_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PN_W-1:0]        tag_q  [NUM_ENTRIES];
  logic [PN_W-1:0]        data_q [NUM_ENTRIES];

  // Scan from the top down so the lowest matching index is the one left
  // standing. Duplicates are never created, so this only fixes a tie-break.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == lookup_page_i)) begin
        hit_o      = 1'b1;
        hit_data_o = data_q[i];
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (inval_i) begin
      valid_d = '0;
      ptr_d   = '0;
    end else if (fill_i) begin
      valid_d[ptr_q] = 1'b1;
      ptr_d = (ptr_q == PTR_W'(NUM_ENTRIES - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  // NOTE: tag/data arrays are deliberately not reset; an entry is only ever
  // observed through its valid bit, which is reset.
  always_ff @(posedge clk) begin
    if (fill_i && !inval_i) begin
      tag_q[ptr_q]  <= fill_page_i;
      data_q[ptr_q] <= fill_data_i;
    end
  end

endmodule

// File: rtl/mcpu_core_fetch_xlate.sv
// -----------------------------------------------------------------------------
// mcpu_core_fetch_xlate
// Fetch PC generator with virtual-to-physical page translation. Holds the
// fetch PC, translates its page through a micro-ITLB, and on a miss requests
// the page from the shared ITLB. A faulting page parks the fetch in FAULT
// until the pipeline redirects it.
//
// Ports
//   clkrst_core_clk    : clock, rising edge
//   clkrst_core_rst_n  : synchronous active-low reset
//   pipe_flush         : redirect PC to pc2ft_newpc (abandons any ITLB request)
//   pc2ft_newpc        : redirect target
//   paging_on          : translation enable (off: physical page = virtual page)
//   uitlb_inval        : invalidate all micro-ITLB entries
//   ft2f_progress      : fetch consumed the current PC
//   ft2f_done          : current PC has a usable translation (or a fault)
//   ft2f_out_virtpc    : current virtual PC
//   ft2f_out_physpage  : translated physical page
//   ft2f_out_inst_pf   : current PC faulted
//   ft2itlb_valid      : ITLB request pending (MISS only)
//   ft2itlb_virtpage   : page number of the current PC
//   ft2itlb_ready      : ITLB response this cycle
//   ft2itlb_physpage   : ITLB physical page
//   ft2itlb_pagefault  : ITLB reports a fault
// -----------------------------------------------------------------------------
module mcpu_core_fetch_xlate
  import mcpu_core_fetch_pkg::*;
#(
  parameter  int unsigned PC_W        = PC_W_DEF,
  parameter  int unsigned PG_OFF_W    = PG_OFF_W_DEF,
  parameter  int unsigned NUM_ENTRIES = 4,
  localparam int unsigned PN_W        = PC_W - PG_OFF_W
) (
  input  logic            clkrst_core_clk,
  input  logic            clkrst_core_rst_n,
  input  logic            pipe_flush,
  input  logic [PC_W-1:0] pc2ft_newpc,
  input  logic            paging_on,
  input  logic            uitlb_inval,
  input  logic            ft2f_progress,
  output logic            ft2f_done,
  output logic [PC_W-1:0] ft2f_out_virtpc,
  output logic [PN_W-1:0] ft2f_out_physpage,
  output logic            ft2f_out_inst_pf,
  output logic            ft2itlb_valid,
  output logic [PN_W-1:0] ft2itlb_virtpage,
  input  logic            ft2itlb_ready,
  input  logic [PN_W-1:0] ft2itlb_physpage,
  input  logic            ft2itlb_pagefault
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PN_W-1:0] cur_page;
  logic            cam_hit;
  logic [PN_W-1:0] cam_data;
  logic            fill_en;

  assign cur_page         = pc_q[PC_W-1:PG_OFF_W];
  assign ft2f_out_virtpc  = pc_q;
  assign ft2itlb_virtpage = cur_page;

  mcpu_core_uitlb_cam #(
    .PN_W        (PN_W),
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_cam (
    .clk           (clkrst_core_clk),
    .rst_n         (clkrst_core_rst_n),
    .lookup_page_i (cur_page),
    .hit_o         (cam_hit),
    .hit_data_o    (cam_data),
    .fill_i        (fill_en),
    .fill_page_i   (cur_page),
    .fill_data_i   (ft2itlb_physpage),
    .inval_i       (uitlb_inval)
  );

  always_comb begin
    state_d           = state_q;
    fill_en           = 1'b0;
    ft2f_done         = 1'b0;
    ft2f_out_physpage = '0;
    ft2f_out_inst_pf  = 1'b0;
    ft2itlb_valid     = 1'b0;

    if (!paging_on) begin
      // Identity mapping; also drops any outstanding request or fault.
      ft2f_done         = 1'b1;
      ft2f_out_physpage = cur_page;
      state_d           = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (cam_hit) begin
            ft2f_done         = 1'b1;
            ft2f_out_physpage = cam_data;
          end else begin
            state_d = ST_MISS;
          end
        end
        ST_MISS: begin
          ft2itlb_valid = 1'b1;
          if (ft2itlb_ready) begin
            if (ft2itlb_pagefault) begin
              state_d = ST_FAULT;
            end else begin
              fill_en = 1'b1;
              state_d = ST_RUN;
            end
          end
        end
        ST_FAULT: begin
          ft2f_done        = 1'b1;
          ft2f_out_inst_pf = 1'b1;
        end
        default: state_d = ST_RUN;
      endcase
    end

    // A redirect discards whatever this cycle produced, including a
    // coincident ITLB response.
    if (pipe_flush) begin
      ft2f_done = 1'b0;
      fill_en   = 1'b0;
      state_d   = ST_RUN;
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (pipe_flush) begin
      pc_d = pc2ft_newpc;
    end else if (ft2f_done && ft2f_progress && (state_q != ST_FAULT)) begin
      pc_d = pc_q + 1'b1;  // wraps naturally at 2^PC_W
    end
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_mcpu_core_fetch_xlate.sv
// -----------------------------------------------------------------------------
// tb_mcpu_core_fetch_xlate
// Scoreboard bench: each fetch segment is predicted up front from a page-level
// model (FIFO-replacement translation cache, fixed page map, fixed ITLB
// latency per page) and pushed into a queue; a monitor pops one expectation
// per consumed fetch. An ITLB responder process answers requests.
// -----------------------------------------------------------------------------
module tb_mcpu_core_fetch_xlate;

  localparam int PC_W        = 28;
  localparam int PG_OFF_W    = 8;
  localparam int PN_W        = 20;
  localparam int NUM_ENTRIES = 4;
  localparam int unsigned PC_MASK = 32'h0FFF_FFFF;
  localparam int unsigned PN_MASK = 32'h000F_FFFF;

  logic            clk;
  logic            rst_n;
  logic            pipe_flush;
  logic [PC_W-1:0] pc2ft_newpc;
  logic            paging_on;
  logic            uitlb_inval;
  logic            ft2f_progress;
  logic            ft2f_done;
  logic [PC_W-1:0] ft2f_out_virtpc;
  logic [PN_W-1:0] ft2f_out_physpage;
  logic            ft2f_out_inst_pf;
  logic            ft2itlb_valid;
  logic [PN_W-1:0] ft2itlb_virtpage;
  logic            ft2itlb_ready;
  logic [PN_W-1:0] ft2itlb_physpage;
  logic            ft2itlb_pagefault;

  mcpu_core_fetch_xlate #(
    .PC_W        (PC_W),
    .PG_OFF_W    (PG_OFF_W),
    .NUM_ENTRIES (NUM_ENTRIES)
  ) dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .pipe_flush        (pipe_flush),
    .pc2ft_newpc       (pc2ft_newpc),
    .paging_on         (paging_on),
    .uitlb_inval       (uitlb_inval),
    .ft2f_progress     (ft2f_progress),
    .ft2f_done         (ft2f_done),
    .ft2f_out_virtpc   (ft2f_out_virtpc),
    .ft2f_out_physpage (ft2f_out_physpage),
    .ft2f_out_inst_pf  (ft2f_out_inst_pf),
    .ft2itlb_valid     (ft2itlb_valid),
    .ft2itlb_virtpage  (ft2itlb_virtpage),
    .ft2itlb_ready     (ft2itlb_ready),
    .ft2itlb_physpage  (ft2itlb_physpage),
    .ft2itlb_pagefault (ft2itlb_pagefault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checking
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------- ref model
  typedef struct {
    int unsigned pc;
    int unsigned phys;
    bit          pf;
    bit          miss;
    int          low;   // cycles with done=0 before this fetch is usable
  } exp_t;

  exp_t        exp_q[$];
  int unsigned tlb[$];        // resident pages, oldest first
  bit          fault_page2 = 1'b0;
  int          consumed = 0;
  int          resp_mode = 0; // 0 normal, 2 force ready this cycle

  function automatic int unsigned map_page(input int unsigned p);
    return (p ^ 32'h0000_0ABD) & PN_MASK;
  endfunction

  function automatic bit is_fault(input int unsigned p);
    return ((p & 32'hF) == 32'hD) || (fault_page2 && (p == 2));
  endfunction

  function automatic int lat(input int unsigned p);
    return int'(p % 3);
  endfunction

  function automatic bit tlb_has(input int unsigned p);
    foreach (tlb[i]) if (tlb[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  // Predicts the next n consumed fetches from pc0; stops after a fault.
  function automatic void predict(input int unsigned pc0, input bit pg, input int n,
                                  output int cnt, output bit last_pf,
                                  output int unsigned last_pc);
    int unsigned pc = pc0 & PC_MASK;
    int unsigned pg_n;
    exp_t e;
    cnt = 0;
    last_pf = 1'b0;
    last_pc = pc;
    for (int i = 0; i < n; i++) begin
      pg_n = pc >> PG_OFF_W;
      e.pc = pc; e.pf = 1'b0; e.miss = 1'b0; e.low = 0;
      if (!pg) begin
        e.phys = pg_n;
      end else if (tlb_has(pg_n)) begin
        e.phys = map_page(pg_n);
      end else begin
        e.miss = 1'b1;
        e.low  = lat(pg_n) + 2;
        if (is_fault(pg_n)) begin
          e.phys = 0; e.pf = 1'b1;
        end else begin
          e.phys = map_page(pg_n);
          tlb.push_back(pg_n);
          if (tlb.size() > NUM_ENTRIES) void'(tlb.pop_front());
        end
      end
      exp_q.push_back(e);
      cnt++;
      last_pc = pc;
      if (e.pf) begin
        last_pf = 1'b1;
        break;
      end
      pc = (pc + 1) & PC_MASK;
    end
  endfunction

  // ------------------------------------------------------------- responder
  initial begin
    int miss_cnt = 0;
    int unsigned vp;
    ft2itlb_ready = 1'b0; ft2itlb_physpage = '0; ft2itlb_pagefault = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (ft2itlb_valid) begin
        vp = 32'(ft2itlb_virtpage);
        ft2itlb_physpage  = PN_W'(map_page(vp));
        ft2itlb_pagefault = is_fault(vp);
        ft2itlb_ready     = (resp_mode == 2) || (resp_mode == 0 && miss_cnt == lat(vp));
        miss_cnt++;
      end else begin
        miss_cnt = 0;
        ft2itlb_ready     = 1'b0;
        ft2itlb_physpage  = PN_W'($urandom);
        ft2itlb_pagefault = 1'($urandom);
      end
    end
  end

  // --------------------------------------------------------------- monitor
  initial begin
    int lowcnt = 0;
    bit saw_req = 1'b0;
    bit pf_seen = 1'b0;
    int unsigned req_page = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (pipe_flush) begin
        check("done_during_flush", ft2f_done, 0);
        lowcnt = 0; saw_req = 1'b0; pf_seen = 1'b0;
      end else begin
        if (ft2itlb_valid && !saw_req) begin
          saw_req  = 1'b1;
          req_page = 32'(ft2itlb_virtpage);
        end
        if (!ft2f_done) lowcnt++;
        if (ft2f_done && ft2f_progress && !(ft2f_out_inst_pf && pf_seen)) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_fetch: got pc 0x%0h, expected no fetch", ft2f_out_virtpc);
          end else begin
            e = exp_q.pop_front();
            check("virtpc",   32'(ft2f_out_virtpc),   e.pc);
            check("physpage", 32'(ft2f_out_physpage), e.phys);
            check("inst_pf",  32'(ft2f_out_inst_pf),  32'(e.pf));
            check("itlb_req", 32'(saw_req),           32'(e.miss));
            check("latency",  lowcnt,                 e.low);
            if (e.miss) check("itlb_virtpage", req_page, e.pc >> PG_OFF_W);
            consumed++;
            if (e.pf) pf_seen = 1'b1;
            lowcnt = 0; saw_req = 1'b0;
          end
        end
      end
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_seg(input int target);
    int base = consumed;
    int cyc  = 0;
    forever begin
      next_cycle();
      pipe_flush  = 1'b0;
      uitlb_inval = 1'b0;
      if (consumed - base >= target) begin
        ft2f_progress = 1'b0;
        return;
      end
      ft2f_progress = ($urandom_range(0, 3) != 0);
      cyc++;
      if (cyc > 3000) begin
        checks++; errors++;
        $display("FAIL seg_timeout: got %0d fetches, expected %0d", consumed - base, target);
        exp_q.delete();
        ft2f_progress = 1'b0;
        return;
      end
    end
  endtask

  task automatic seg(input int unsigned newpc, input bit pg, input int n, input bit inv);
    int cnt;
    bit last_pf;
    int unsigned last_pc;
    pipe_flush    = 1'b1;
    pc2ft_newpc   = PC_W'(newpc);
    paging_on     = pg;
    uitlb_inval   = inv;
    ft2f_progress = 1'b0;
    if (inv) tlb.delete();
    predict(newpc, pg, n, cnt, last_pf, last_pc);
    run_seg(cnt);
    if (last_pf) begin
      // A faulted fetch must stay put even while the consumer keeps asking.
      ft2f_progress = 1'b1;
      repeat (3) begin
        @(negedge clk);
        check("fault_pc_held", 32'(ft2f_out_virtpc), last_pc);
        check("fault_pf",      32'(ft2f_out_inst_pf), 1);
        check("fault_done",    32'(ft2f_done), 1);
        next_cycle();
      end
      ft2f_progress = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ft2f_done && cyc < 20);
    check(name, 32'(ft2f_done), 1);
  endtask

  task automatic wait_req(input string name);
    int cyc = 0;
    while (!ft2itlb_valid && cyc < 20) begin
      next_cycle();
      cyc++;
    end
    check(name, 32'(ft2itlb_valid), 1);
  endtask

  // Flush racing an ITLB response, then invalidate racing a fill.
  task automatic flush_and_inval_races();
    pipe_flush = 1'b1; pc2ft_newpc = 28'h0000700; paging_on = 1'b1;
    ft2f_progress = 1'b0; uitlb_inval = 1'b0;
    next_cycle();
    pipe_flush = 1'b0;
    wait_req("race1_req");
    pipe_flush = 1'b1; pc2ft_newpc = 28'h0000705; resp_mode = 2;
    next_cycle();
    pipe_flush = 1'b0; resp_mode = 0;
    @(negedge clk);
    check("flush_discards_fill", 32'(ft2f_done), 0);
    check("flush_loads_pc",      32'(ft2f_out_virtpc), 32'h705);
    check("flush_no_fault",      32'(ft2f_out_inst_pf), 0);
    wait_done("race1_refill");
    check("race1_phys", 32'(ft2f_out_physpage), map_page(7));
    tlb.push_back(7);
    if (tlb.size() > NUM_ENTRIES) void'(tlb.pop_front());

    next_cycle();
    pipe_flush = 1'b1; pc2ft_newpc = 28'h0000800;
    next_cycle();
    pipe_flush = 1'b0;
    wait_req("race2_req");
    uitlb_inval = 1'b1; resp_mode = 2;
    next_cycle();
    uitlb_inval = 1'b0; resp_mode = 0;
    @(negedge clk);
    check("inval_beats_fill", 32'(ft2f_done), 0);
    wait_done("race2_refill");
    check("race2_phys", 32'(ft2f_out_physpage), map_page(8));
    tlb.delete();
    tlb.push_back(8);
    next_cycle();
  endtask

  initial begin
    int unsigned pg_pick, pc_pick;
    rst_n = 1'b0; pipe_flush = 1'b0; pc2ft_newpc = '0; paging_on = 1'b1;
    uitlb_inval = 1'b0; ft2f_progress = 1'b1;

    // Reset with paging on: empty table, so no hit and no request.
    repeat (3) @(negedge clk);
    check("rst_done_pg_on", 32'(ft2f_done), 0);
    check("rst_itlb_valid", 32'(ft2itlb_valid), 0);
    check("rst_pf",         32'(ft2f_out_inst_pf), 0);
    check("rst_virtpc",     32'(ft2f_out_virtpc), 0);

    next_cycle();
    rst_n = 1'b1; paging_on = 1'b0; ft2f_progress = 1'b0;
    @(negedge clk);
    check("rst_done_pg_off", 32'(ft2f_done), 1);
    check("rst_phys_pg_off", 32'(ft2f_out_physpage), 0);

    begin : boot_identity
      int cnt; bit lpf; int unsigned lpc;
      predict(0, 1'b0, 3, cnt, lpf, lpc);
      run_seg(cnt);
    end

    seg(32'h0000100, 1'b1, 255, 1'b0);                   // page 1 miss then hits
    seg(32'h0000200, 1'b1, 1, 1'b0);                     // fill pages 2..5
    seg(32'h0000300, 1'b1, 1, 1'b0);
    seg(32'h0000400, 1'b1, 1, 1'b0);
    seg(32'h0000500, 1'b1, 1, 1'b0);                     // evicts page 1
    seg(32'h0000510, 1'b1, 1, 1'b0);                     // page 5 hits
    seg(32'h0000120, 1'b1, 1, 1'b0);                     // page 1 misses

    fault_page2 = 1'b1;
    seg(32'h0000200, 1'b1, 1, 1'b1);                     // fault on page 2
    fault_page2 = 1'b0;
    seg(32'h0000300, 1'b1, 4, 1'b0);

    flush_and_inval_races();

    seg(32'h0FFFFFFF, 1'b1, 3, 1'b0);                    // PC wraps to 0

    for (int s = 0; s < 40; s++) begin
      pg_pick = $urandom_range(0, 16);
      if (pg_pick == 16) pg_pick = PN_MASK;
      pc_pick = (pg_pick << PG_OFF_W) |
                (($urandom_range(0, 1) != 0) ? $urandom_range(0, 255) : $urandom_range(248, 255));
      seg(pc_pick, ($urandom_range(0, 4) != 0), $urandom_range(1, 12),
          ($urandom_range(0, 7) == 0));
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mcpu_core_fetch_xlate.md
MCPU_CORE_FETCH_XLATE -- requirements
Module: mcpu_core_fetch_xlate

Interface
REQ-001 SHALL have parameter PC_W, default 28: virtual PC width in instruction words.
REQ-002 SHALL have parameter PG_OFF_W, default 8: page-offset bits; page number width PN_W = PC_W-PG_OFF_W.
REQ-003 SHALL have parameter NUM_ENTRIES, default 4: micro-ITLB entries, legal values 1..16.
REQ-004 SHALL have port clkrst_core_clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port clkrst_core_rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port pipe_flush, input, 1: redirect PC to pc2ft_newpc.
REQ-007 SHALL have port pc2ft_newpc, input, PC_W: redirect target.
REQ-008 SHALL have port paging_on, input, 1: translation enable.
REQ-009 SHALL have port uitlb_inval, input, 1: invalidate all micro-ITLB entries.
REQ-010 SHALL have port ft2f_progress, input, 1: fetch consumed current PC.
REQ-011 SHALL have ports ft2f_done (out, 1), ft2f_out_virtpc (out, PC_W), ft2f_out_physpage (out, PN_W), ft2f_out_inst_pf (out, 1).
REQ-012 SHALL have ports ft2itlb_valid (out, 1), ft2itlb_virtpage (out, PN_W), ft2itlb_ready (in, 1), ft2itlb_physpage (in, PN_W), ft2itlb_pagefault (in, 1).

Function
REQ-013 SHALL implement states RUN, MISS, FAULT; reset state RUN.
REQ-014 paging_on=0: ft2f_done=1, physpage=virtpc[PC_W-1:PG_OFF_W], inst_pf=0, no lookup, ft2itlb_valid=0; state forced to RUN.
REQ-015 RUN, paging_on=1: fully-associative lookup of virtpc page number against valid entries, combinational; hit -> done=1, physpage=entry data, zero added latency.
REQ-016 RUN miss -> done=0; next state MISS.
REQ-017 MISS: ft2itlb_valid=1, ft2itlb_virtpage=current page number, done=0; held until ft2itlb_ready=1.
REQ-018 MISS with ready=1, pagefault=0: write {page, ft2itlb_physpage} into entry at round-robin pointer, set valid, pointer increments mod NUM_ENTRIES; next state RUN (hit following cycle).
REQ-019 MISS with ready=1, pagefault=1: no fill; next state FAULT.
REQ-020 FAULT: done=1, inst_pf=1, physpage=0; PC frozen regardless of ft2f_progress; exit only via pipe_flush or reset.
REQ-021 ft2itlb_virtpage SHALL equal current page number in all states; ft2itlb_valid SHALL be 1 only in MISS.
REQ-022 PC update priority: pipe_flush loads pc2ft_newpc, next state RUN; else done & ft2f_progress & state!=FAULT increments PC by 1, wrapping mod 2^PC_W.
REQ-023 ft2f_done SHALL be 0 in any cycle with pipe_flush=1.
REQ-024 pipe_flush in MISS SHALL abandon the request; a coincident ready/physpage/pagefault SHALL be discarded (no fill, no FAULT).
REQ-025 uitlb_inval clears all valid bits and pointer to 0 next cycle; over a coincident fill, invalidation wins; lookup in the inval cycle uses pre-invalidation contents.
REQ-026 Duplicate page entries SHALL NOT be created; on multiple hits (never expected) lowest index wins.
REQ-027 paging_on falling in MISS SHALL abandon the request as in REQ-024.

Reset
REQ-028 On clkrst_core_rst_n=0 at a rising edge: virtpc=0, state=RUN, all valid bits=0, pointer=0; overrides flush, inval and fill.
REQ-029 Outputs after reset: ft2itlb_valid=0, inst_pf=0; done per REQ-014/016 from paging_on and empty table.
REQ-030 Entry tag/data storage need not be reset.

Structure
REQ-031 Package mcpu_core_fetch_pkg SHALL hold PC_W/PG_OFF_W defaults and the RUN/MISS/FAULT state encoding.
REQ-032 Sub-module mcpu_core_uitlb_cam (lookup, fill, invalidate, round-robin pointer) SHALL be used; FSM and PC stay top-level.

Verification
REQ-033 Reset, paging_on=0, progress=1 for 3 cycles -> virtpc 0,1,2; physpage=virtpc>>8; done=1.
REQ-034 paging_on=1, flush newpc=0x0000100, ITLB returns 0x00ABC after 2 cycles -> done low 3 cycles, physpage=0x00ABC, next PCs 0x101..0x1FF hit with done=1.
REQ-035 Fill pages 1..5 with NUM_ENTRIES=4 -> page 1 evicted; revisit page 1 misses, page 5 hits.
REQ-036 ITLB pagefault=1 for page 0x00002 -> inst_pf=1, done=1, PC held under progress; flush newpc=0x300 -> RUN, inst_pf=0.
REQ-037 Flush coincident with ready in MISS -> no fill, PC=newpc; uitlb_inval with fill -> next access misses.
REQ-038 virtpc=0xFFFFFFF, hit, progress=1 -> virtpc wraps to 0x0000000.
